// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage, one outstanding imem request, redirect/kill handling
// Optional FETCH_PERF_CNT_EN adds fetch_count (instructions handed to decode).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = imem_resp_data;
            out_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end
      end
      HOLD: if (!out_valid_q || out_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; a request already in flight is
    // marked so its response is dropped when it finally arrives.
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      unique case (state_q)
        REQ: begin
          kill_d  = imem_req_ready;
          state_d = imem_req_ready ? WAIT : REQ;
        end
        WAIT: begin
          kill_d  = !imem_resp_valid;
          state_d = imem_resp_valid ? REQ : WAIT;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
    end else if (out_valid_q && out_ready) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - random and directed bench for fetch_stage with a transaction-level model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model: program counter, whether a request is in flight, whether its
  // response is stale, and the decode-facing output register.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_oinstr = 32'd0;
  logic [31:0] m_opc = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  bit m_first = 1'b1;
  bit m_out = 1'b0;
  bit m_stale = 1'b0;
  bit m_ovalid = 1'b0;

  int lat_cnt = 0;
  int fixed_lat = 1;
  bit rand_mode = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  logic [31:0] hs_q[$];
  logic [31:0] op_q[$];
  logic [31:0] oi_q[$];

  function automatic bit m_req();
    return !m_first && !m_out && !m_ovalid;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("req_valid", 32'(imem_req_valid), 32'(m_req()));
    check("req_addr", imem_req_addr, m_pc);
    check("out_valid", 32'(out_valid), 32'(m_ovalid));
    check("out_instr", out_instr, m_oinstr);
    check("out_pc", out_pc, m_opc);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic model_step();
    bit acc;
    bit cons;
    if (!rst_n) return;
    if (m_first) begin
      m_first = 1'b0;
      if (redirect_valid) m_pc = redirect_pc;
      return;
    end
    acc  = m_req() && imem_req_ready;
    cons = m_ovalid && out_ready;
    if (cons) begin
      m_ovalid = 1'b0;
      m_cnt = m_cnt + 32'd1;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc;
      m_ovalid = 1'b0;
      if (acc) begin
        m_out = 1'b1;
        m_stale = 1'b1;
      end else if (m_out) begin
        if (imem_resp_valid) begin
          m_out = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (acc) begin
      m_out = 1'b1;
    end else if (m_out && imem_resp_valid) begin
      m_out = 1'b0;
      if (m_stale) begin
        m_stale = 1'b0;
      end else begin
        m_ovalid = 1'b1;
        m_oinstr = imem_resp_data;
        m_opc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    if (check_en) compare();
    imem_resp_valid = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = rand_mode ? $urandom() : ~pend_addr;
      end
    end
    imem_req_ready = rdy;
    out_ready = ordy;
    redirect_valid = redir;
    redirect_pc = rpc;
    if (imem_req_valid && rdy) begin
      lat_cnt = rand_mode ? int'($urandom_range(1, 3)) : fixed_lat;
      pend_addr = imem_req_addr;
      hs_q.push_back(imem_req_addr);
    end
    if (out_valid && ordy) begin
      op_q.push_back(out_pc);
      oi_q.push_back(out_instr);
    end
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (check_en) compare();
    #2;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b0;
    lat_cnt = 0;
    m_pc = 32'h0000_0000;
    m_first = 1'b1;
    m_out = 1'b0;
    m_stale = 1'b0;
    m_ovalid = 1'b0;
    m_oinstr = 32'd0;
    m_opc = 32'd0;
    m_cnt = 32'd0;
    @(negedge clk);
    check_en = 1'b1;
    compare();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    // A response in the first cycle after release must be ignored.
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    model_step();
    hs_q.delete();
    op_q.delete();
    oi_q.delete();
  endtask

  initial begin
    logic [31:0] exp_w[3];
    exp_w = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};

    do_reset();
    rand_mode = 1'b0;
    fixed_lat = 1;
    repeat (14) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("seq_req_addr", at(hs_q, i), 32'(4 * i));
      check("seq_out_pc", at(op_q, i), 32'(4 * i));
      check("seq_out_instr", at(oi_q, i), exp_w[i]);
    end

    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_pc", out_pc, 32'h0000_0000);
      check("stall_out_instr", out_instr, 32'hFFFF_FFFF);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    check("stall_req_count", 32'(hs_q.size()), 32'd1);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'd0);

    do_reset();
    fixed_lat = 2;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("wait_redir_req_addr", at(hs_q, 1), 32'h0000_0100);
    check("wait_redir_out_pc", at(op_q, 0), 32'h0000_0100);
    check("wait_redir_out_instr", at(oi_q, 0), 32'hFFFF_FEFF);

    do_reset();
    fixed_lat = 1;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("resp_redir_out_valid", 32'(out_valid), 32'd0);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("resp_redir_req_addr", at(hs_q, 1), 32'h0000_0200);
    check("resp_redir_out_pc", at(op_q, 0), 32'h0000_0200);

    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    check("wrap_req_addr0", at(hs_q, 0), 32'hFFFF_FFFC);
    check("wrap_req_addr1", at(hs_q, 1), 32'h0000_0000);
    check("wrap_out_pc0", at(op_q, 0), 32'hFFFF_FFFC);
    check("wrap_out_pc1", at(op_q, 1), 32'h0000_0000);

    rand_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if (i == 1500) do_reset();
      rpc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 11) == 0, rpc);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
